// File: rtl/framebuffer_writer.sv
// framebuffer_writer
// Buffers 4-bit gray pixels from the iteration core and hands them to the
// RP2040 framebuffer one nibble at a time over a toggle/ack handshake.
// Optional feature: define FB_WRITER_TIMEOUT_EN to enable the ack timeout,
// which sets a sticky error_out and abandons the frame when the RP2040 stops
// answering. Without the macro WAIT_ACK waits forever and error_out is 0.

module framebuffer_writer #(
    parameter int PIXEL_COUNT    = 76800,
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_in,
    input  logic [3:0] pixel_in,
    input  logic       pixel_valid_in,
    output logic       pixel_ready_out,
    output logic [3:0] write_data_out,
    output logic       write_toggle_out,
    input  logic       write_ack_in,
    output logic       reset_write_ptr_out,
    output logic       busy_out,
    output logic       frame_done_out,
    output logic       error_out
);

    // Widths: counters must hold PIXEL_COUNT itself, pointers index the FIFO
    localparam int CNT_W = $clog2(PIXEL_COUNT + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PRC_W = (PTR_RST_CYCLES > 1) ? $clog2(PTR_RST_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIXEL_COUNT);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [PRC_W-1:0] PRC_LAST  = PRC_W'(PTR_RST_CYCLES - 1);

`ifdef FB_WRITER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR_RST,
        ST_LOAD,
        ST_STROBE,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         fifo_mem_q [FIFO_DEPTH];
    logic [3:0]         fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   accepted_q, accepted_d;
    logic [CNT_W-1:0]   written_q, written_d;
    logic [PRC_W-1:0]   prc_q, prc_d;
    logic               ack_meta_q, ack_meta_d;
    logic               ack_sync_q, ack_sync_d;
    logic [3:0]         write_data_q, write_data_d;
    logic               toggle_q, toggle_d;
    logic               rst_ptr_q, rst_ptr_d;
    logic               frame_done_q, frame_done_d;
`ifdef FB_WRITER_TIMEOUT_EN
    logic               error_q, error_d;
    logic [TO_W-1:0]    timeout_q, timeout_d;
`endif

    logic push;
    logic pop;
    logic flush;
    logic outstanding;

    // Pointer advance with explicit wrap so a depth of one still works
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign outstanding = (toggle_q != ack_sync_q);

    assign pixel_ready_out = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                             (occ_q != OCC_FULL) && (accepted_q < PIX_TOTAL);

    assign push = pixel_valid_in && pixel_ready_out;

    // Next-state, handshake and FIFO bookkeeping for one cycle
    always_comb begin
        state_d      = state_q;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        accepted_d   = accepted_q;
        written_d    = written_q;
        prc_d        = prc_q;
        ack_meta_d   = write_ack_in;
        ack_sync_d   = ack_meta_q;
        write_data_d = write_data_q;
        toggle_d     = toggle_q;
        rst_ptr_d    = rst_ptr_q;
        frame_done_d = 1'b0;
`ifdef FB_WRITER_TIMEOUT_EN
        error_d      = error_q;
        timeout_d    = timeout_q;
`endif
        pop          = 1'b0;
        flush        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d    = ST_PTR_RST;
                    rst_ptr_d  = 1'b1;
                    prc_d      = '0;
                    accepted_d = '0;
                    written_d  = '0;
                    flush      = 1'b1;
`ifdef FB_WRITER_TIMEOUT_EN
                    error_d    = 1'b0;
`endif
                end
            end
            ST_PTR_RST: begin
                if (prc_q == PRC_LAST) begin
                    rst_ptr_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    prc_d = prc_q + PRC_W'(1);
                end
            end
            ST_LOAD: begin
                if (occ_q != '0) begin
                    write_data_d = fifo_mem_q[rd_ptr_q];
                    pop          = 1'b1;
                    state_d      = ST_STROBE;
                end
            end
            ST_STROBE: begin
                toggle_d  = ~toggle_q;
                written_d = written_q + CNT_W'(1);
                state_d   = ST_WAIT_ACK;
`ifdef FB_WRITER_TIMEOUT_EN
                timeout_d = '0;
`endif
            end
            ST_WAIT_ACK: begin
                if (!outstanding) begin
                    if (written_q == PIX_TOTAL) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
`ifdef FB_WRITER_TIMEOUT_EN
                else if (timeout_q == TO_LAST) begin
                    error_d = 1'b1;
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timeout_d = timeout_q + TO_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = pixel_in;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
                accepted_d           = accepted_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // All state lives here; reset drops everything, including the toggle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fifo_mem_q   <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            accepted_q   <= '0;
            written_q    <= '0;
            prc_q        <= '0;
            ack_meta_q   <= 1'b0;
            ack_sync_q   <= 1'b0;
            write_data_q <= '0;
            toggle_q     <= 1'b0;
            rst_ptr_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FB_WRITER_TIMEOUT_EN
            error_q      <= 1'b0;
            timeout_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            accepted_q   <= accepted_d;
            written_q    <= written_d;
            prc_q        <= prc_d;
            ack_meta_q   <= ack_meta_d;
            ack_sync_q   <= ack_sync_d;
            write_data_q <= write_data_d;
            toggle_q     <= toggle_d;
            rst_ptr_q    <= rst_ptr_d;
            frame_done_q <= frame_done_d;
`ifdef FB_WRITER_TIMEOUT_EN
            error_q      <= error_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign write_data_out      = write_data_q;
    assign write_toggle_out    = toggle_q;
    assign reset_write_ptr_out = rst_ptr_q;
    assign busy_out            = (state_q != ST_IDLE);
    assign frame_done_out      = frame_done_q;
`ifdef FB_WRITER_TIMEOUT_EN
    assign error_out           = error_q;
`else
    assign error_out           = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer
// Drives small frames into framebuffer_writer, models the RP2040 ack echo and
// scores every written nibble against the pixels that were accepted.

module tb_framebuffer_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_in = 1'b0;
    logic [3:0] pixel_in = 4'h0;
    logic       pixel_valid_in = 1'b0;
    logic       pixel_ready_out;
    logic [3:0] write_data_out;
    logic       write_toggle_out;
    logic       write_ack_in = 1'b0;
    logic       reset_write_ptr_out;
    logic       busy_out;
    logic       frame_done_out;
    logic       error_out;

    int checkCount = 0;
    int errorCount = 0;
    int toggleCount = 0;
    int doneCount = 0;
    int ptrHighCount = 0;

    logic [3:0] expQ[$];
    logic [3:0] popVal;
    logic       prevToggle = 1'b0;
    logic [1:0] ackPipe = 2'b00;
    logic       ackEn = 1'b0;

    framebuffer_writer #(
        .PIXEL_COUNT    (4),
        .FIFO_DEPTH     (4),
        .PTR_RST_CYCLES (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_in            (start_in),
        .pixel_in            (pixel_in),
        .pixel_valid_in      (pixel_valid_in),
        .pixel_ready_out     (pixel_ready_out),
        .write_data_out      (write_data_out),
        .write_toggle_out    (write_toggle_out),
        .write_ack_in        (write_ack_in),
        .reset_write_ptr_out (reset_write_ptr_out),
        .busy_out            (busy_out),
        .frame_done_out      (frame_done_out),
        .error_out           (error_out)
    );

    always #5 clk = ~clk;

    // RP2040 model: echoes the toggle back two cycles later while enabled
    always @(negedge clk) begin
        if (!rst_n) begin
            ackPipe      = 2'b00;
            write_ack_in = 1'b0;
        end else if (ackEn) begin
            write_ack_in = ackPipe[1];
            ackPipe      = {ackPipe[0], write_toggle_out};
        end
    end

    // Output monitor: every toggle edge pops the scoreboard and checks the nibble
    always @(negedge clk) begin
        if (!rst_n) begin
            prevToggle = write_toggle_out;
        end else begin
            if (write_toggle_out !== prevToggle) begin
                toggleCount++;
                if (expQ.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    popVal = expQ.pop_front();
                    checkOutput("write_data", {28'd0, write_data_out}, {28'd0, popVal});
                end
            end
            prevToggle = write_toggle_out;
            if (frame_done_out) doneCount++;
            if (reset_write_ptr_out) ptrHighCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Offer one pixel for up to budget cycles; expected value queued on acceptance
    task automatic applyStimulus(input logic [3:0] value, input int budget,
                                 output bit accepted);
        int n;
        n = 0;
        accepted = 1'b0;
        @(negedge clk);
        pixel_in = value;
        pixel_valid_in = 1'b1;
        while (!accepted && n < budget) begin
            if (pixel_ready_out) begin
                accepted = 1'b1;
                expQ.push_back(value);
            end
            @(negedge clk);
            n++;
        end
        pixel_valid_in = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic waitFrameDone(input string tag);
        int n;
        n = 0;
        while (!frame_done_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, {31'd0, frame_done_out}, 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, {31'd0, pixel_ready_out}, 32'd0);
        checkOutput({tag, "_data"}, {28'd0, write_data_out}, 32'd0);
        checkOutput({tag, "_toggle"}, {31'd0, write_toggle_out}, 32'd0);
        checkOutput({tag, "_ptr_rst"}, {31'd0, reset_write_ptr_out}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, frame_done_out}, 32'd0);
        checkOutput({tag, "_error"}, {31'd0, error_out}, 32'd0);
    endtask

    // Runs the frame scenarios in order and prints the summary
    initial begin
        logic [3:0] f1Pix [4];
        bit   acc;
        int   accCount;
        bit   fifthAcc;
        int   tBase;
        int   dBase;
        int   pBase;
        int   n;
        logic t0;

        f1Pix = '{4'h3, 4'hA, 4'h5, 4'hF};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Start pulse: pointer reset held exactly four cycles, busy next cycle
        ackEn = 1'b1;
        pBase = ptrHighCount;
        pulseStart();
        checkOutput("busy_after_start", {31'd0, busy_out}, 32'd1);
        checkOutput("ptr_rst_first", {31'd0, reset_write_ptr_out}, 32'd1);
        repeat (8) @(negedge clk);
        checkOutput("ptr_rst_cycles", ptrHighCount - pBase, 32'd4);

        // Frame 1: fixed pixels, prompt acks
        tBase = toggleCount;
        dBase = doneCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(f1Pix[i], 50, acc);
            checkOutput("f1_accept", {31'd0, acc}, 32'd1);
        end
        waitFrameDone("f1");
        @(negedge clk);
        checkOutput("f1_idle", {31'd0, busy_out}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("f1_toggles", toggleCount - tBase, 32'd4);
        checkOutput("f1_done_pulses", doneCount - dBase, 32'd1);
        checkOutput("f1_sb_empty", expQ.size(), 32'd0);

        // Frame 2: acks withheld, five offered, start pulsed mid-frame
        ackEn = 1'b0;
        tBase = toggleCount;
        dBase = doneCount;
        pulseStart();
        accCount = 0;
        fifthAcc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 20, acc);
            if (acc) accCount++;
            if (i == 4) fifthAcc = acc;
        end
        checkOutput("f2_accepted", accCount, 32'd4);
        checkOutput("f2_fifth_rejected", {31'd0, fifthAcc}, 32'd0);
        checkOutput("f2_ready_low", {31'd0, pixel_ready_out}, 32'd0);
        checkOutput("f2_one_nibble", toggleCount - tBase, 32'd1);
        pulseStart();
        repeat (3) @(negedge clk);
        checkOutput("f2_start_ignored_ptr", {31'd0, reset_write_ptr_out}, 32'd0);
        checkOutput("f2_still_busy", {31'd0, busy_out}, 32'd1);
        checkOutput("f2_still_one_nibble", toggleCount - tBase, 32'd1);
        ackEn = 1'b1;
        waitFrameDone("f2");
        @(negedge clk);
        checkOutput("f2_idle", {31'd0, busy_out}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("f2_toggles", toggleCount - tBase, 32'd4);
        checkOutput("f2_done_pulses", doneCount - dBase, 32'd1);
        checkOutput("f2_sb_empty", expQ.size(), 32'd0);

        // Frame 3: reset while waiting for the second ack
        ackEn = 1'b0;
        tBase = toggleCount;
        dBase = doneCount;
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 20, acc);
            checkOutput("f3_accept", {31'd0, acc}, 32'd1);
        end
        n = 0;
        while ((toggleCount - tBase) < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("f3_first_nibble", {31'd0, (toggleCount - tBase) >= 1}, 32'd1);
        ackEn = 1'b1;
        n = 0;
        while ((toggleCount - tBase) < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("f3_second_nibble", {31'd0, (toggleCount - tBase) >= 2}, 32'd1);
        ackEn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        repeat (3) @(negedge clk);
        checkOutput("f3_no_done", doneCount - dBase, 32'd0);
        expQ.delete();
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 4: normal frame after the abandoned one
        ackEn = 1'b1;
        tBase = toggleCount;
        dBase = doneCount;
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 50, acc);
            checkOutput("f4_accept", {31'd0, acc}, 32'd1);
        end
        waitFrameDone("f4");
        repeat (4) @(negedge clk);
        checkOutput("f4_toggles", toggleCount - tBase, 32'd4);
        checkOutput("f4_done_pulses", doneCount - dBase, 32'd1);
        checkOutput("f4_sb_empty", expQ.size(), 32'd0);
        checkOutput("f4_idle", {31'd0, busy_out}, 32'd0);

`ifdef FB_WRITER_TIMEOUT_EN
        // Ack never returns: error after sixteen WAIT_ACK cycles, cleared by start
        ackEn = 1'b0;
        dBase = doneCount;
        t0 = write_toggle_out;
        pulseStart();
        applyStimulus(4'h9, 50, acc);
        checkOutput("to_accept", {31'd0, acc}, 32'd1);
        n = 0;
        while (write_toggle_out === t0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_strobed", {31'd0, write_toggle_out !== t0}, 32'd1);
        n = 0;
        while (!error_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_cycles", n, 32'd16);
        checkOutput("to_error", {31'd0, error_out}, 32'd1);
        checkOutput("to_idle", {31'd0, busy_out}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("to_error_sticky", {31'd0, error_out}, 32'd1);
        checkOutput("to_no_done", doneCount - dBase, 32'd0);
        pulseStart();
        checkOutput("to_error_cleared", {31'd0, error_out}, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expQ.delete();
        rst_n = 1'b1;
        @(negedge clk);
`else
        checkOutput("error_tied_low", {31'd0, error_out}, 32'd0);
        t0 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/framebuffer_writer.md
FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SHALL have parameter PIXEL_COUNT, default 76800, pixels per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two), input buffer entries.
REQ-003 SHALL have parameter PTR_RST_CYCLES, default 4, cycles reset_write_ptr_out is held high.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, ack timeout (used only with macro).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 SHALL have port start_in  input  1  single-cycle pulse starting a frame.
REQ-008 SHALL have port pixel_in  input  4  gray pixel from the iteration core.
REQ-009 SHALL have port pixel_valid_in  input  1  pixel_in valid.
REQ-010 SHALL have port pixel_ready_out  output  1  pixel accepted when valid and ready both high.
REQ-011 SHALL have port write_data_out  output  4  nibble driven to framebuffer write_data_in.
REQ-012 SHALL have port write_toggle_out  output  1  toggles once per nibble, drives framebuffer write_data.
REQ-013 SHALL have port write_ack_in  input  1  toggle acknowledge from the RP2040, asynchronous.
REQ-014 SHALL have port reset_write_ptr_out  output  1  drives framebuffer reset_write_ptr.
REQ-015 SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-016 SHALL have port frame_done_out  output  1  one-cycle pulse when the last nibble is acknowledged.
REQ-017 SHALL have port error_out  output  1  sticky ack-timeout flag.

Function
REQ-018 SHALL synchronize write_ack_in through two flops; "outstanding" = write_toggle_out != synchronized ack.
REQ-019 SHALL implement states IDLE, PTR_RST, LOAD, STROBE, WAIT_ACK, DONE.
REQ-020 IDLE: start_in -> PTR_RST, clear pixel counters and FIFO; start_in in any other state SHALL be ignored.
REQ-021 PTR_RST: reset_write_ptr_out=1 for exactly PTR_RST_CYCLES cycles, then LOAD.
REQ-022 LOAD: if FIFO non-empty, pop head into write_data_out and go to STROBE; else stay.
REQ-023 STROBE: invert write_toggle_out (data stable one full cycle before the edge), increment written count, go WAIT_ACK.
REQ-024 WAIT_ACK: when not outstanding -> DONE if written count == PIXEL_COUNT, else LOAD.
REQ-025 DONE: frame_done_out=1 for one cycle, then IDLE.
REQ-026 pixel_ready_out SHALL be 1 only when state is not IDLE/DONE, FIFO not full, and accepted count < PIXEL_COUNT.
REQ-027 FIFO SHALL allow push and pop in the same cycle, including when full (ready already low, so no push) or empty (pop blocked).
REQ-028 Counters SHALL be $clog2(PIXEL_COUNT+1) bits wide; no wrap within a frame.
REQ-029 Pixels offered after PIXEL_COUNT accepted SHALL not be accepted (ready stays 0).
REQ-030 write_toggle_out SHALL retain its level across frames (not reset at frame start).
REQ-031 Minimum per-nibble cost SHALL be 4 cycles (LOAD, STROBE, 2 sync stages) plus ack latency.

Reset
REQ-032 On rst_n low, immediately: state IDLE, FIFO empty, counters 0, ack synchronizer 0.
REQ-033 Reset values: pixel_ready_out 0, write_data_out 0, write_toggle_out 0, reset_write_ptr_out 0, busy_out 0, frame_done_out 0, error_out 0.
REQ-034 Reset mid-frame SHALL abandon the frame with no frame_done_out pulse.

Configuration
REQ-035 Macro FB_WRITER_TIMEOUT_EN defined: WAIT_ACK counts cycles; reaching TIMEOUT_CYCLES sets error_out, flushes FIFO, goes IDLE without frame_done_out; error_out clears only on next start_in or reset.
REQ-036 Macro undefined: no timeout counter, WAIT_ACK waits indefinitely, error_out tied 0.

Verification (PIXEL_COUNT=4, FIFO_DEPTH=4, PTR_RST_CYCLES=4)
REQ-037 Reset, start_in pulse -> reset_write_ptr_out high exactly 4 cycles, busy_out 1 from next cycle.
REQ-038 Push 0x3,0xA,0x5,0xF; ack echoes toggle after 2 cycles -> write_data_out sequence 3,A,5,F, four toggles, one frame_done_out, then IDLE.
REQ-039 Ack withheld, 5 pixels offered -> ready drops after 4 accepted (FIFO full minus in-flight rule honored), 5th never accepted.
REQ-040 start_in pulsed during WAIT_ACK -> ignored, frame completes normally.
REQ-041 rst_n low during WAIT_ACK after 2 nibbles -> all outputs at reset values immediately, no frame_done_out.
REQ-042 With FB_WRITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never returned -> error_out 1 after 16 WAIT_ACK cycles, state IDLE; next start_in clears it.
